// File: rtl/data_store_rx_if.sv
// Bus bundle for data_store_rx: inbound symbol stream, drain request,
// outbound word stream and frame status.
interface data_store_rx_if #(
  parameter int N         = 2,
  parameter int DATA_SIZE = 16
) ();
  logic                 axiiv;
  logic [N-1:0]         axiid;
  logic                 read_request;
  logic                 axiov;
  logic [DATA_SIZE-1:0] axiod;
  logic                 frame_done;
  logic                 overflow;
  logic [15:0]          data_cksum;
  logic [15:0]          data_length;

  // Design side
  modport slave (
    input  axiiv, axiid, read_request,
    output axiov, axiod, frame_done, overflow, data_cksum, data_length
  );

  // Stimulus side
  modport master (
    output axiiv, axiid, read_request,
    input  axiov, axiod, frame_done, overflow, data_cksum, data_length
  );
endinterface

// File: rtl/data_store_rx.sv
// data_store_rx: assembles an N-bit symbol stream into DATA_SIZE-bit words,
// stores one frame in a block RAM while computing its one's-complement
// checksum and byte length, then streams the frame back out on request.
module data_store_rx #(
  parameter int N         = 2,
  parameter int DATA_SIZE = 16,
  parameter int DEPTH     = 256
) (
  input  logic           clk,
  input  logic           rst,
  data_store_rx_if.slave bus
);
  localparam int SPW = DATA_SIZE / N;                    // symbols per word
  localparam int SCW = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int IW  = $clog2(DEPTH + 1);                // index can reach DEPTH
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_FLUSH} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_STREAM} rstate_t;

  // One's-complement add with the end-around carry folded back in.
  function automatic logic [15:0] fold_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [DATA_SIZE-1:0] ram_q, dout_q;

  // Write side state
  wstate_t              wstate_q;
  logic [IW-1:0]        widx_q;
  logic [SCW-1:0]       sym_cnt_q;
  logic [DATA_SIZE-1:0] word_q;
  logic [18:0]          bit_cnt_q;
  logic [15:0]          acc_q;
  logic [7:0]           hi_q;      // first byte of an unpaired byte pair (DATA_SIZE=8)
  logic                 pend_q;
  logic                 overflow_q, frame_done_q, stored_q;
  logic [15:0]          cksum_q, length_q;

  // Read side state
  rstate_t              rstate_q;
  logic [IW-1:0]        rd_idx_q, out_cnt_q;
  logic                 wait_q, axiov_q;

  // Write datapath helpers
  logic                 idle, sym_ok, word_full, flush_wr, we;
  logic [SCW-1:0]       k_eff;
  logic [DATA_SIZE-1:0] base_word, asm_word, wdata;
  logic [IW-1:0]        idx_eff;
  logic [AW-1:0]        waddr;
  logic [18:0]          bit_cnt_b;
  logic [15:0]          acc_b, acc_w, acc_fin, asm16, word16;
  logic [7:0]           hi_w;
  logic                 pend_b, pend_w;

  // Symbol placement, RAM write port and checksum next values. In W_IDLE the
  // per-frame state is treated as cleared so the first symbol lands at k=0.
  always_comb begin
    idle      = (wstate_q == W_IDLE);
    k_eff     = idle ? '0 : sym_cnt_q;
    base_word = idle ? '0 : word_q;
    idx_eff   = idle ? '0 : widx_q;
    bit_cnt_b = idle ? '0 : bit_cnt_q;
    acc_b     = idle ? 16'd0 : acc_q;
    pend_b    = idle ? 1'b0 : pend_q;
    // Once DEPTH words are stored nothing more is accepted, so length and
    // checksum stay frozen at the last stored word.
    sym_ok    = bus.axiiv && (idle || (wstate_q == W_RECV && widx_q < IW'(DEPTH)));
    asm_word  = base_word | (DATA_SIZE'(bus.axiid) << (DATA_SIZE - N - N * int'(k_eff)));
    word_full = (k_eff == SCW'(SPW - 1));
    flush_wr  = (wstate_q == W_RECV) && !bus.axiiv && (sym_cnt_q != '0);
    we        = (sym_ok && word_full) || flush_wr;
    waddr     = idx_eff[AW-1:0];
    wdata     = flush_wr ? word_q : asm_word;
    asm16     = 16'(asm_word) << (16 - DATA_SIZE);
    word16    = 16'(word_q) << (16 - DATA_SIZE);

    acc_w  = acc_b;
    pend_w = pend_b;
    hi_w   = hi_q;
    if (sym_ok && word_full) begin
      if (DATA_SIZE == 16) begin
        acc_w = fold_add(acc_b, asm16);
      end else if (pend_b) begin
        acc_w  = fold_add(acc_b, {hi_q, 8'(asm16 >> 8)});
        pend_w = 1'b0;
      end else begin
        hi_w   = 8'(asm16 >> 8);
        pend_w = 1'b1;
      end
    end

    // Closing contribution: only whole bytes enter the checksum, matching
    // data_length, so a trailing fragment under 8 bits adds nothing.
    acc_fin = acc_q;
    if (DATA_SIZE == 16) begin
      if (flush_wr && (N * int'(sym_cnt_q) >= 8))
        acc_fin = fold_add(acc_q, word16 & 16'hFF00);
    end else if (pend_q) begin
      acc_fin = fold_add(acc_q, {hi_q, 8'h00});
    end
  end

  // Write FSM: receive, flush the partial word, publish length/checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q     <= W_IDLE;
      widx_q       <= '0;
      sym_cnt_q    <= '0;
      word_q       <= '0;
      bit_cnt_q    <= '0;
      acc_q        <= '0;
      hi_q         <= '0;
      pend_q       <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      stored_q     <= 1'b0;
      cksum_q      <= 16'hFFFF;
      length_q     <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (sym_ok) begin
        sym_cnt_q <= word_full ? '0 : k_eff + 1'b1;
        word_q    <= word_full ? '0 : asm_word;
        widx_q    <= word_full ? idx_eff + 1'b1 : idx_eff;
        bit_cnt_q <= bit_cnt_b + 19'(N);
        acc_q     <= acc_w;
        hi_q      <= hi_w;
        pend_q    <= pend_w;
      end
      case (wstate_q)
        W_IDLE: if (bus.axiiv) begin
          wstate_q   <= W_RECV;
          overflow_q <= 1'b0;
          stored_q   <= 1'b0;
        end
        W_RECV: begin
          if (bus.axiiv) begin
            if (!sym_ok) overflow_q <= 1'b1;
          end else begin
            wstate_q     <= W_FLUSH;
            frame_done_q <= 1'b1;
            cksum_q      <= ~acc_fin;
            length_q     <= 16'(bit_cnt_q >> 3);
            widx_q       <= widx_q + IW'(flush_wr);
            sym_cnt_q    <= '0;
            word_q       <= '0;
            stored_q     <= (widx_q != '0) || flush_wr;
          end
        end
        W_FLUSH: wstate_q <= W_IDLE;
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Frame buffer: one write port, two-stage registered read path.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    ram_q  <= mem[rd_idx_q[AW-1:0]];
    dout_q <= ram_q;
  end

  // Read FSM: the address runs two words ahead of the output to cover the
  // RAM latency; a new frame or a dropped request ends the stream at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      rd_idx_q  <= '0;
      out_cnt_q <= '0;
      wait_q    <= 1'b0;
      axiov_q   <= 1'b0;
    end else if (rstate_q != R_IDLE && (bus.axiiv || !bus.read_request)) begin
      rstate_q <= R_IDLE;
      axiov_q  <= 1'b0;
    end else begin
      case (rstate_q)
        R_IDLE: if (bus.read_request && stored_q && wstate_q == W_IDLE && !bus.axiiv) begin
          rd_idx_q <= '0;
          wait_q   <= 1'b0;
          rstate_q <= R_WAIT;
        end
        R_WAIT: begin
          rd_idx_q <= rd_idx_q + 1'b1;
          wait_q   <= 1'b1;
          if (wait_q) begin
            rstate_q  <= R_STREAM;
            axiov_q   <= 1'b1;
            out_cnt_q <= '0;
          end
        end
        R_STREAM: begin
          if (out_cnt_q == widx_q - 1'b1) begin
            axiov_q  <= 1'b0;
            rstate_q <= R_IDLE;
          end else begin
            out_cnt_q <= out_cnt_q + 1'b1;
            rd_idx_q  <= rd_idx_q + 1'b1;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign bus.axiov       = axiov_q;
  assign bus.axiod       = dout_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.overflow    = overflow_q;
  assign bus.data_cksum  = cksum_q;
  assign bus.data_length = length_q;

endmodule
